// File: rtl/imm_gen_pipe.sv
// Purpose: RV32I/RV64I immediate generator (I/S/B/J/U/SHAMT) behind a valid/ready stage with a 2-entry skid buffer.
// Latency: 1 cycle from input accept to out_valid; sustains 1 result per cycle while out_ready=1.
// Backpressure: in_ready is a pure register output (!skid_full); stalls absorb one extra entry, order is FIFO.
//
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready      upstream handshake; instr + imm_src sampled on accept
//   flush                  drops the output register and skid entry at the next edge
//   out_valid/out_ready    downstream handshake for imm_ext + imm_illegal
//   illegal_cnt            saturating count of accepted illegal imm_src selects
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic             imm_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  // Opcode bits never contribute to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  // ---------------------------------------------------------------------------
  // Immediate extraction. Every format is first built as a 32-bit value that is
  // already correct for RV32; a signed size cast then replicates bit 31 upward
  // for RV64. SHAMT has bit 31 clear, so the cast zero-extends it.
  // ---------------------------------------------------------------------------
  logic [31:0]     imm32;
  logic            new_ill;
  logic [XLEN-1:0] new_imm;

  always_comb begin
    imm32   = 32'd0;
    new_ill = 1'b0;
    case (imm_src)
      3'b000: imm32 = {{20{instr[31]}}, instr[31:20]};
      3'b001: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'b010: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      3'b011: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      3'b100: imm32 = {instr[31:12], 12'd0};
      3'b101: imm32 = (XLEN == 64) ? {26'd0, instr[25:20]} : {27'd0, instr[24:20]};
      default: begin
        imm32   = 32'd0;
        new_ill = 1'b1;
      end
    endcase
    new_imm = XLEN'($signed(imm32));
  end

  // ---------------------------------------------------------------------------
  // Output register + skid entry
  // ---------------------------------------------------------------------------
  logic             out_vld_q, out_vld_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  logic             out_ill_q, out_ill_d;
  logic             skid_vld_q, skid_vld_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic             skid_ill_q, skid_ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic accept;
  logic xfer;

  // The skid entry is the only thing that can block a new input, so in_ready
  // comes straight off a flop and never sees out_ready combinationally.
  assign in_ready = !skid_vld_q;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_vld_q && out_ready;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_imm_d  = out_imm_q;
    out_ill_d  = out_ill_q;
    skid_vld_d = skid_vld_q;
    skid_imm_d = skid_imm_q;
    skid_ill_d = skid_ill_q;
    cnt_d      = cnt_q;

    if (flush) begin
      // Anything accepted this cycle is dropped along with both entries;
      // a transfer in this cycle has already completed downstream.
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || xfer) begin
      // Output register is free at this edge: the skid entry (older) goes
      // first, and a concurrent accept refills the skid behind it.
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_imm_d  = skid_imm_q;
        out_ill_d  = skid_ill_q;
        skid_vld_d = accept;
        if (accept) begin
          skid_imm_d = new_imm;
          skid_ill_d = new_ill;
        end
      end else begin
        out_vld_d = accept;
        if (accept) begin
          out_imm_d = new_imm;
          out_ill_d = new_ill;
        end
      end
    end else if (accept) begin
      // Output stalled and holding data: park the new entry in the skid.
      skid_vld_d = 1'b1;
      skid_imm_d = new_imm;
      skid_ill_d = new_ill;
    end

    // Counts every accepted illegal select, flushed or not.
    if (accept && new_ill && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_imm_q  <= '0;
      out_ill_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_imm_q <= '0;
      skid_ill_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_imm_q  <= out_imm_d;
      out_ill_q  <= out_ill_d;
      skid_vld_q <= skid_vld_d;
      skid_imm_q <= skid_imm_d;
      skid_ill_q <= skid_ill_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid   = out_vld_q;
  assign imm_ext     = out_imm_q;
  assign imm_illegal = out_ill_q;
  assign illegal_cnt = cnt_q;

endmodule
